frontend_freelist: RTL and testbench
====================================

FRONTEND_FREELIST -- requirements
Module: frontend_freelist

Interface
REQ-001 SHALL have the port `clk`: input, 1 bit, the single rising-edge clock.
REQ-002 SHALL have the port `reset`: input, 1 bit, asynchronous, active-low reset.
REQ-003 SHALL have the ports `alloc_req1` and `alloc_req2`: input, 1 bit each, slot 1/2 needs a new physical destination (wr_reg && !invalid).
REQ-004 SHALL have the ports `phy_dst_1` and `phy_dst_2`: output, `PHY_REG_SEL bits each, the physical registers granted to slot 1/2 and fed to the RAT phy_dst_1/2.
REQ-005 SHALL have the port `stall`: output, 1 bit, high when the requested count exceeds the free count.
REQ-006 SHALL have the ports `free_en1` and `free_en2`: input, 1 bit each, the commit stage returns a physical register.
REQ-007 SHALL have the ports `free_phy_1` and `free_phy_2`: input, `PHY_REG_SEL bits each, the returned registers (the old phy_ori_dst of the retired instruction).
REQ-008 SHALL have the port `free_count`: output, `PHY_REG_SEL+1 bits, the number of valid entries.
REQ-009 SHALL have the port `empty`: output, 1 bit, high when free_count==0.

Function
REQ-010 SHALL be a circular FIFO of PHY_REG_NUM=2^`PHY_REG_SEL entries, with head/tail pointers of `PHY_REG_SEL bits that wrap naturally modulo PHY_REG_NUM.
REQ-011 SHALL drive phy_dst_1=fifo[head] combinationally.
REQ-012 SHALL drive phy_dst_2=fifo[head+1] when alloc_req1 is high, else fifo[head].
REQ-013 SHALL compute n_alloc=alloc_req1+alloc_req2 and drive stall=(n_alloc>free_count) combinationally.
REQ-014 SHALL, on a rising edge with stall low, advance head by n_alloc.
REQ-015 SHALL, on a stall, perform no allocation and keep head unchanged, with partial grants forbidden.
REQ-016 SHALL, on a rising edge, write free_phy_1 at tail if free_en1.
REQ-017 SHALL write free_phy_2 at tail+free_en1 if free_en2, and advance tail by free_en1+free_en2.
REQ-018 SHALL ignore a free of physical register 0 (reserved), counting it as not asserted.
REQ-019 SHALL update next free_count = free_count - granted_alloc + n_free in the same edge.
REQ-020 SHALL NOT bypass same-cycle frees to allocation: at free_count 0 with req and free both active, stall is high and the freed entries become visible next cycle.
REQ-021 SHALL drop a free that would exceed PHY_REG_NUM-1 entries and leave free_count saturated; this is a protocol error flagged by a bench assertion.

Reset
REQ-022 SHALL, while reset is low (asynchronously), set fifo[i]=i+1 for i=0..PHY_REG_NUM-2, head=0, tail=PHY_REG_NUM-1, free_count=PHY_REG_NUM-1, stall=0 and empty=0; p0 is the initial mapping of every architectural register in the RAT.
REQ-023 SHALL apply reset asserted mid-allocation immediately, discarding pending grants.
REQ-024 SHALL resume operation on the first rising edge after reset deassertion.

Configuration
REQ-025 SHALL, when FREELIST_RECOVER_EN is defined, add the inputs `flush` (1 bit) and `retire_alloc1`/`retire_alloc2` (1 bit each), and keep an arch_head pointer that advances by retire_alloc1+retire_alloc2 per edge.
REQ-026 SHALL, under FREELIST_RECOVER_EN, on flush set head<=arch_head (the post-retire value this edge), ignore alloc requests that cycle, hold stall low, process same-cycle frees normally, and recompute free_count=tail-head.
REQ-027 SHALL, when FREELIST_RECOVER_EN is undefined, have no flush/retire ports and no arch_head, leaving recovery to a full reset.

Structure
REQ-028 SHALL place PHY_REG_NUM and the pointer/count widths, derived from `PHY_REG_SEL and `REG_NUM, in the shared frontend package alongside the RAT constants.
REQ-029 SHALL implement storage as one sub-module frontend_freelist_ram: 2 combinational read ports, 2 write ports, and no reset on its data (initialisation is done by the parent via reset-loaded registers).

Verification (PHY_REG_SEL=6, 64 entries)
REQ-030 SHALL test reset release: free_count=63, phy_dst_1=1, phy_dst_2=2 with both reqs, stall=0.
REQ-031 SHALL test 31 cycles of dual alloc: granted p1..p62 in order, free_count=1; the next dual req gives stall=1, head unchanged; a single alloc_req2 gets phy_dst_2=63 with stall=0.
REQ-032 SHALL test, at free_count=0, free_en1(p5)+alloc_req1 in the same cycle: stall=1; next cycle phy_dst_1=5 and the grant succeeds.
REQ-033 SHALL test free of p0 with free_en1: free_count unchanged and tail unchanged.
REQ-034 SHALL test tail wrap, freeing p7,p9 at tail=63: fifo[63]=7, fifo[0]=9, tail=1; a later allocation returns 7 then 9.
REQ-035 SHALL test, under FREELIST_RECOVER_EN, allocating 4 with 1 retired and then flush: head=arch_head=1, free_count=62, and the next phy_dst_1=2.

Source files
------------

// File: rtl/frontend_freelist_pkg.sv
// Shared frontend constants: physical/architectural register sizing for the RAT and free list.
// Sizing comes from `PHY_REG_SEL and `REG_NUM (defaults below if not supplied by the build).
`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif

package frontend_freelist_pkg;
    localparam int PHY_SEL      = `PHY_REG_SEL;
    localparam int PHY_REG_NUM  = 1 << PHY_SEL;
    localparam int PTR_W        = PHY_SEL;
    localparam int CNT_W        = PHY_SEL + 1;
    localparam int ARCH_REG_NUM = `REG_NUM;
    localparam int ARCH_SEL     = $clog2(ARCH_REG_NUM);

    // Reset image of the free list: entry i holds p(i+1); p0 stays mapped in the RAT.
    function automatic logic [PHY_SEL-1:0] init_entry(input logic [PTR_W-1:0] idx);
        return idx + PTR_W'(1);
    endfunction
endpackage

// File: rtl/frontend_freelist_ram.sv
// Free-list storage: 2 combinational read ports, 2 write ports, no reset on data.
module frontend_freelist_ram
    import frontend_freelist_pkg::*;
(
    input  logic               clk,
    input  logic [PTR_W-1:0]   rd_addr1,
    input  logic [PTR_W-1:0]   rd_addr2,
    output logic [PHY_SEL-1:0] rd_data1,
    output logic [PHY_SEL-1:0] rd_data2,
    input  logic               wr_en1,
    input  logic [PTR_W-1:0]   wr_addr1,
    input  logic [PHY_SEL-1:0] wr_data1,
    input  logic               wr_en2,
    input  logic [PTR_W-1:0]   wr_addr2,
    input  logic [PHY_SEL-1:0] wr_data2
);
    logic [PHY_SEL-1:0] mem [PHY_REG_NUM];

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

    always_ff @(posedge clk) begin
        if (wr_en1) mem[wr_addr1] <= wr_data1;
        if (wr_en2) mem[wr_addr2] <= wr_data2;
    end
endmodule

// File: rtl/frontend_freelist.sv
// Physical register free list: circular FIFO with dual allocate and dual free per cycle.
// Define FREELIST_RECOVER_EN to add flush recovery via a retired (architectural) head pointer.
module frontend_freelist
    import frontend_freelist_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               alloc_req1,
    input  logic               alloc_req2,
    output logic [PHY_SEL-1:0] phy_dst_1,
    output logic [PHY_SEL-1:0] phy_dst_2,
    output logic               stall,
    input  logic               free_en1,
    input  logic               free_en2,
    input  logic [PHY_SEL-1:0] free_phy_1,
    input  logic [PHY_SEL-1:0] free_phy_2,
`ifdef FREELIST_RECOVER_EN
    input  logic               flush,
    input  logic               retire_alloc1,
    input  logic               retire_alloc2,
`endif
    output logic [CNT_W-1:0]   free_count,
    output logic               empty
);
    logic [PTR_W-1:0]       head, tail, rd_addr2, wr_addr2;
    logic [PTR_W-1:0]       head_nxt, tail_nxt, recover_head;
    logic [PHY_SEL-1:0]     ram_rd1, ram_rd2;
    logic [PHY_REG_NUM-1:0] loaded;
    logic [1:0]             n_alloc, n_grant;
    logic [CNT_W-1:0]       avail, avail1, count_nxt;
    logic                   do_flush, ok1, ok2;

`ifdef FREELIST_RECOVER_EN
    logic [PTR_W-1:0] arch_head, arch_head_nxt;

    assign do_flush      = flush;
    assign arch_head_nxt = arch_head + PTR_W'(retire_alloc1) + PTR_W'(retire_alloc2);
    assign recover_head  = arch_head_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) arch_head <= '0;
        else        arch_head <= arch_head_nxt;
    end
`else
    assign do_flush     = 1'b0;
    assign recover_head = head;
`endif

    assign rd_addr2 = alloc_req1 ? head + PTR_W'(1) : head;

    frontend_freelist_ram u_ram (
        .clk      (clk),
        .rd_addr1 (head),
        .rd_addr2 (rd_addr2),
        .rd_data1 (ram_rd1),
        .rd_data2 (ram_rd2),
        .wr_en1   (ok1),
        .wr_addr1 (tail),
        .wr_data1 (free_phy_1),
        .wr_en2   (ok2),
        .wr_addr2 (wr_addr2),
        .wr_data2 (free_phy_2)
    );

    // Entries never written since reset read back their reset image instead of RAM contents.
    assign phy_dst_1 = loaded[head]     ? ram_rd1 : init_entry(head);
    assign phy_dst_2 = loaded[rd_addr2] ? ram_rd2 : init_entry(rd_addr2);

    assign n_alloc = {1'b0, alloc_req1} + {1'b0, alloc_req2};
    assign stall   = !do_flush && (CNT_W'(n_alloc) > free_count);
    assign n_grant = (stall || do_flush) ? 2'd0 : n_alloc;

    // Frees are admitted against the post-allocation count; p0 and overflow frees are dropped.
    assign avail  = free_count - CNT_W'(n_grant);
    assign ok1    = free_en1 && (free_phy_1 != '0) && (avail < CNT_W'(PHY_REG_NUM - 1));
    assign avail1 = avail + CNT_W'(ok1);
    assign ok2    = free_en2 && (free_phy_2 != '0) && (avail1 < CNT_W'(PHY_REG_NUM - 1));

    assign wr_addr2  = tail + PTR_W'(ok1);
    assign tail_nxt  = wr_addr2 + PTR_W'(ok2);
    assign head_nxt  = do_flush ? recover_head : head + PTR_W'(n_grant);
    assign count_nxt = do_flush ? CNT_W'(tail_nxt - head_nxt) : avail1 + CNT_W'(ok2);
    assign empty     = (free_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= PTR_W'(PHY_REG_NUM - 1);
            free_count <= CNT_W'(PHY_REG_NUM - 1);
            loaded     <= '0;
        end else begin
            head       <= head_nxt;
            tail       <= tail_nxt;
            free_count <= count_nxt;
            if (ok1) loaded[tail]     <= 1'b1;
            if (ok2) loaded[wr_addr2] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_frontend_freelist.sv
// Scoreboard bench for frontend_freelist: queue-based reference model of free tags,
// directed corner cases followed by randomized alloc/free traffic.
module tb_frontend_freelist;
    import frontend_freelist_pkg::*;

`ifdef FREELIST_RECOVER_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               alloc_req1 = 1'b0, alloc_req2 = 1'b0;
    logic               free_en1 = 1'b0, free_en2 = 1'b0;
    logic [PHY_SEL-1:0] free_phy_1 = '0, free_phy_2 = '0;
    logic               flush = 1'b0, retire_alloc1 = 1'b0, retire_alloc2 = 1'b0;
    logic [PHY_SEL-1:0] phy_dst_1, phy_dst_2;
    logic               stall, empty;
    logic [CNT_W-1:0]   free_count;

    frontend_freelist dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_req1    (alloc_req1),
        .alloc_req2    (alloc_req2),
        .phy_dst_1     (phy_dst_1),
        .phy_dst_2     (phy_dst_2),
        .stall         (stall),
        .free_en1      (free_en1),
        .free_en2      (free_en2),
        .free_phy_1    (free_phy_1),
        .free_phy_2    (free_phy_2),
`ifdef FREELIST_RECOVER_EN
        .flush         (flush),
        .retire_alloc1 (retire_alloc1),
        .retire_alloc2 (retire_alloc2),
`endif
        .free_count    (free_count),
        .empty         (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit chk1;
        int d1;
        bit chk2;
        int d2;
        bit stall;
        int cnt;
    } exp_t;

    exp_t expq[$];
    int   freeq[$];    // free tags in allocation order
    int   spec[$];     // allocated, not yet retired (recovery build only)
    int   retired[$];  // allocated and safe to return
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string nm, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("stall", int'(stall), int'(e.stall));
            check("free_count", int'(free_count), e.cnt);
            check("empty", int'(empty), int'(e.cnt == 0));
            if (e.chk1) check("phy_dst_1", int'(phy_dst_1), e.d1);
            if (e.chk2) check("phy_dst_2", int'(phy_dst_2), e.d2);
        end
    end

    function automatic void model_reset();
        freeq.delete();
        spec.delete();
        retired.delete();
        for (int i = 1; i < PHY_REG_NUM; i++) freeq.push_back(i);
    endfunction

    // Expected outputs for the current cycle from the free queue as it stands.
    function automatic bit push_expect(input bit r1, input bit r2, input bit fl);
        exp_t e;
        int   sz = freeq.size();
        e.stall = !fl && ((int'(r1) + int'(r2)) > sz);
        e.cnt   = sz;
        e.chk1  = sz >= 1;
        e.d1    = (sz >= 1) ? freeq[0] : 0;
        if (r1) begin
            e.chk2 = sz >= 2;
            e.d2   = (sz >= 2) ? freeq[1] : 0;
        end else begin
            e.chk2 = sz >= 1;
            e.d2   = (sz >= 1) ? freeq[0] : 0;
        end
        expq.push_back(e);
        return e.stall;
    endfunction

    function automatic void grant(input int p);
        if (REC) spec.push_back(p);
        else     retired.push_back(p);
    endfunction

    function automatic int take_retired();
        int idx = $urandom_range(0, retired.size() - 1);
        int p   = retired[idx];
        retired.delete(idx);
        return p;
    endfunction

    task automatic step(input bit r1, input bit r2, input bit fe1, input int fp1,
                        input bit fe2, input int fp2, input bit fl, input bit rt1, input bit rt2);
        bit st, fle;
        fle = fl && REC;
        @(posedge clk); #1;
        alloc_req1 = r1;  alloc_req2 = r2;
        free_en1 = fe1;   free_phy_1 = PHY_SEL'(fp1);
        free_en2 = fe2;   free_phy_2 = PHY_SEL'(fp2);
        flush = fle;      retire_alloc1 = rt1 && REC;  retire_alloc2 = rt2 && REC;
        st = push_expect(r1, r2, fle);
        if (REC) repeat (int'(rt1) + int'(rt2)) retired.push_back(spec.pop_front());
        if (!st && !fle) begin
            if (r1) grant(freeq.pop_front());
            if (r2) grant(freeq.pop_front());
        end
        if (fle) while (spec.size() > 0) freeq.push_front(spec.pop_back());
        if (fe1 && fp1 != 0) freeq.push_back(fp1);
        if (fe2 && fp2 != 0) freeq.push_back(fp2);
    endtask

    // Reset is raised mid-cycle with both requests held high; outputs must snap to the reset image.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        alloc_req1 = 1'b1; alloc_req2 = 1'b1;
        free_en1 = 1'b0;   free_en2 = 1'b0;
        flush = 1'b0;      retire_alloc1 = 1'b0; retire_alloc2 = 1'b0;
        model_reset();
        void'(push_expect(1'b1, 1'b1, 1'b0));
        @(posedge clk); #1;
        reset = 1'b1;
        alloc_req1 = 1'b0; alloc_req2 = 1'b0;
    endtask

    task automatic drain_all();
        repeat (31) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);  // count 1: dual request must stall
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);  // single request on slot 2 takes the last tag
    endtask

    initial begin
        bit r1, r2, fe1, fe2, fl, rt1, rt2;
        int fp1, fp2, nr;

        do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Exhaust, then free/alloc collide at count 0: no bypass.
        do_reset();
        drain_all();
        if (REC) step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 1, 5, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // p0 free is ignored; then a dual free wraps the tail.
        do_reset();
        drain_all();
        if (REC) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        end
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 1, 9, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        if (REC) begin
            do_reset();
            step(1, 1, 0, 0, 0, 0, 0, 0, 0);
            step(1, 1, 0, 0, 0, 0, 0, 1, 0);
            step(1, 1, 0, 0, 0, 0, 1, 0, 0);
            step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        // Random traffic: only previously granted (retired) tags are returned.
        retired.delete();
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                r1 = $urandom_range(0, 9) < 6;
                r2 = $urandom_range(0, 9) < 6;
                fe1 = 1'b0; fp1 = 0; fe2 = 1'b0; fp2 = 0;
                if (retired.size() > 0 && $urandom_range(0, 1) == 1) begin
                    fe1 = 1'b1; fp1 = take_retired();
                end else if ($urandom_range(0, 15) == 0) begin
                    fe1 = 1'b1;
                end
                if (retired.size() > 0 && $urandom_range(0, 1) == 1) begin
                    fe2 = 1'b1; fp2 = take_retired();
                end else if ($urandom_range(0, 15) == 0) begin
                    fe2 = 1'b1;
                end
                nr  = (spec.size() >= 2) ? $urandom_range(0, 2) : $urandom_range(0, spec.size());
                rt1 = nr >= 1;
                rt2 = nr == 2;
                fl  = $urandom_range(0, 39) == 0;
                step(r1, r2, fe1, fp1, fe2, fp2, fl, rt1, rt2);
            end
        end

        @(posedge clk); #1;
        alloc_req1 = 1'b0; alloc_req2 = 1'b0; free_en1 = 1'b0; free_en2 = 1'b0;
        flush = 1'b0; retire_alloc1 = 1'b0; retire_alloc2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
